// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider: ALU function codes
// and the controller state type.
package divider_pkg;

   localparam logic [5:0] DIVU = 6'b011011;
   localparam logic [5:0] DIV  = 6'b011010;
   localparam logic [5:0] OUT  = 6'b111111;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/divider_if.sv
// Operand/command/result bundle between an ALU front end (master) and the
// divider (slave).
interface divider_if #(
   parameter int WIDTH = 32
);

   logic [WIDTH-1:0]   dataA;
   logic [WIDTH-1:0]   dataB;
   logic [5:0]         Signal;
   logic [2*WIDTH-1:0] dataOut;
   logic               busy;
   logic               done;

   modport master (
      output dataA, dataB, Signal,
      input  dataOut, busy, done
   );

   modport slave (
      input  dataA, dataB, Signal,
      output dataOut, busy, done
   );

endinterface

// File: rtl/divider_step.sv
// One combinational restoring shift-subtract step: shift the next dividend
// bit into the partial remainder and subtract the divisor when it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             nextBit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] newRem,
   output logic             quotBit
);

   logic [WIDTH:0] trial;

   assign trial   = {rem, nextBit};
   assign quotBit = (trial >= {1'b0, divisor});

   // The true difference always fits in WIDTH bits, so wrapping subtraction is exact
   assign newRem = quotBit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider producing {remainder, quotient} after WIDTH
// iterations. Define DIVIDER_SIGNED_EN to add signed division on the DIV code.
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic      clk,
   input logic      reset,
   divider_if.slave bus
);

   localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

   state_t             state;
   logic [5:0]         counter;
   logic [WIDTH-1:0]   dividendReg;
   logic [WIDTH-1:0]   divisorReg;
   logic [WIDTH-1:0]   remReg;
   logic [2*WIDTH-1:0] dataOutReg;
   logic               busyReg;
   logic               doneReg;

   logic [WIDTH-1:0]   stepRem;
   logic               stepBit;
   logic [WIDTH-1:0]   rawQuot;
   logic [WIDTH-1:0]   finalQuot;
   logic [WIDTH-1:0]   finalRem;
   logic               startUnsigned;

`ifdef DIVIDER_SIGNED_EN
   logic               startSigned;
   logic               negQuot;
   logic               negRem;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;

   assign startSigned = (bus.Signal == DIV);
   assign magA        = bus.dataA[WIDTH-1] ? -bus.dataA : bus.dataA;
   assign magB        = bus.dataB[WIDTH-1] ? -bus.dataB : bus.dataB;
`endif

   div_step #(.WIDTH(WIDTH)) step (
      .rem     (remReg),
      .nextBit (dividendReg[WIDTH-1]),
      .divisor (divisorReg),
      .newRem  (stepRem),
      .quotBit (stepBit)
   );

   // The dividend register doubles as the quotient: bits shift out the top
   // into the remainder while quotient bits shift in at the bottom.
   assign startUnsigned = (bus.Signal == DIVU);
   assign rawQuot       = {dividendReg[WIDTH-2:0], stepBit};

`ifdef DIVIDER_SIGNED_EN
   assign finalQuot = negQuot ? -rawQuot : rawQuot;
   assign finalRem  = negRem  ? -stepRem : stepRem;
`else
   assign finalQuot = rawQuot;
   assign finalRem  = stepRem;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         counter     <= '0;
         dividendReg <= '0;
         divisorReg  <= '0;
         remReg      <= '0;
         dataOutReg  <= '0;
         busyReg     <= 1'b0;
         doneReg     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         negQuot     <= 1'b0;
         negRem      <= 1'b0;
`endif
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (startUnsigned) begin
                  dividendReg <= bus.dataA;
                  divisorReg  <= bus.dataB;
                  remReg      <= '0;
                  counter     <= '0;
                  busyReg     <= 1'b1;
                  state       <= RUN;
`ifdef DIVIDER_SIGNED_EN
                  negQuot     <= 1'b0;
                  negRem      <= 1'b0;
`endif
               end
`ifdef DIVIDER_SIGNED_EN
               else if (startSigned) begin
                  dividendReg <= magA;
                  divisorReg  <= magB;
                  remReg      <= '0;
                  counter     <= '0;
                  busyReg     <= 1'b1;
                  state       <= RUN;
                  negQuot     <= bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1];
                  negRem      <= bus.dataA[WIDTH-1];
               end
`endif
               else if ((state == DONE) && (bus.Signal == OUT)) begin
                  state <= IDLE;
               end
            end
            RUN: begin
               dividendReg <= rawQuot;
               remReg      <= stepRem;
               counter     <= counter + 6'd1;
               if (counter == LAST_STEP) begin
                  dataOutReg <= {finalRem, finalQuot};
                  doneReg    <= 1'b1;
                  busyReg    <= 1'b0;
                  state      <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dataOut = dataOutReg;
   assign bus.busy    = busyReg;
   assign bus.done    = doneReg;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: fixed vectors, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_divider;
   import divider_pkg::*;

   localparam int         WIDTH = 32;
   localparam logic [5:0] NOP   = 6'b000000;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   passCount  = 0;
   int   totalCount = 0;

   typedef struct {
      string       name;
      logic [5:0]  sig;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] expOut;
   } vec_t;

   divider_if #(.WIDTH(WIDTH)) bus ();

   divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: plain integer division with the divide-by-zero and overflow rules
   function automatic logic [63:0] refModel(input logic [5:0] sig, input logic [31:0] a,
                                            input logic [31:0] b);
      int sa;
      int sb;
      int q;
      int r;
      if (sig == DIVU) begin
         if (b == 32'd0) return {a, 32'hFFFF_FFFF};
         return {a % b, a / b};
      end
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'd0) return {a, (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      totalCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   // Present a command for exactly one rising edge; returns at the following negedge
   task automatic applyStimulus(input logic [5:0] sig, input logic [31:0] a,
                                input logic [31:0] b);
      bus.Signal = sig;
      bus.dataA  = a;
      bus.dataB  = b;
      @(negedge clk);
      bus.Signal = NOP;
   endtask

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (!bus.done && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic runOp(input string name, input logic [5:0] sig, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expOut);
      int cycles;
      applyStimulus(sig, a, b);
      checkOutput({name, ".busy"}, 64'(bus.busy), 64'd1);
      waitDone(cycles);
      checkOutput({name, ".latency"}, 64'(cycles), 64'(WIDTH));
      checkOutput({name, ".dataOut"}, bus.dataOut, expOut);
      checkOutput({name, ".busyAfter"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      checkOutput({name, ".donePulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      vec_t vecs[$];
      int   cycles;
      int   donePulses;
      int   busySeen;
      logic [63:0] held;

      bus.Signal = NOP;
      bus.dataA  = '0;
      bus.dataB  = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset.dataOut", bus.dataOut, 64'd0);
      checkOutput("reset.busy", 64'(bus.busy), 64'd0);
      checkOutput("reset.done", 64'(bus.done), 64'd0);

      // Start on the very first edge after reset release
      reset = 1'b1;
      runOp("basic100div7", DIVU, 32'd100, 32'd7, 64'h00000002_0000000E);

      vecs.push_back('{"divByZero",   DIVU, 32'h12345678, 32'd0,        64'h12345678_FFFFFFFF});
      vecs.push_back('{"backToBack",  DIVU, 32'd20,       32'd6,        64'h00000002_00000003});
      vecs.push_back('{"maxDivOne",   DIVU, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF});
      vecs.push_back('{"smallByBig",  DIVU, 32'd5,        32'd10,       64'h00000005_00000000});
      vecs.push_back('{"maxByMax",    DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001});
      vecs.push_back('{"msbDiv3",     DIVU, 32'h80000000, 32'd3,        64'h00000002_2AAAAAAA});
      for (int i = 0; i < vecs.size(); i++)
         runOp(vecs[i].name, vecs[i].sig, vecs[i].a, vecs[i].b, vecs[i].expOut);

      // OUT returns to IDLE without disturbing the result; junk codes do nothing
      applyStimulus(OUT, 32'd0, 32'd0);
      checkOutput("outHold.dataOut", bus.dataOut, 64'h00000002_2AAAAAAA);
      busySeen = 0;
      donePulses = 0;
      bus.Signal = 6'h2A;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy) busySeen++;
         if (bus.done) donePulses++;
      end
      bus.Signal = NOP;
      checkOutput("junkCode.busy", 64'(busySeen), 64'd0);
      checkOutput("junkCode.done", 64'(donePulses), 64'd0);

      // A second start and operand changes mid-run must be ignored
      applyStimulus(DIVU, 32'd81, 32'd9);
      cycles = 0;
      donePulses = 0;
      while (donePulses == 0 && cycles < 100) begin
         if (cycles == 4) begin
            bus.Signal = DIVU;
            bus.dataA  = 32'd50;
            bus.dataB  = 32'd5;
         end else if (cycles == 5) begin
            bus.Signal = NOP;
            bus.dataA  = 32'hDEADBEEF;
         end
         @(negedge clk);
         cycles++;
         if (bus.done) donePulses++;
      end
      checkOutput("ignoredStart.latency", 64'(cycles), 64'(WIDTH));
      checkOutput("ignoredStart.dataOut", bus.dataOut, 64'h00000000_00000009);
      repeat (40) begin
         @(negedge clk);
         if (bus.done) donePulses++;
      end
      checkOutput("ignoredStart.pulses", 64'(donePulses), 64'd1);

`ifdef DIVIDER_SIGNED_EN
      vecs.delete();
      vecs.push_back('{"sNeg7div2",   DIV, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD});
      vecs.push_back('{"s7divNeg2",   DIV, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD});
      vecs.push_back('{"sOverflow",   DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000});
      vecs.push_back('{"sNegByZero",  DIV, 32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_00000001});
      for (int i = 0; i < vecs.size(); i++)
         runOp(vecs[i].name, vecs[i].sig, vecs[i].a, vecs[i].b, vecs[i].expOut);
`else
      held = bus.dataOut;
      applyStimulus(DIV, 32'hFFFFFFF9, 32'd2);
      busySeen = 0;
      donePulses = 0;
      repeat (40) begin
         if (bus.busy) busySeen++;
         if (bus.done) donePulses++;
         @(negedge clk);
      end
      checkOutput("divIgnored.busy", 64'(busySeen), 64'd0);
      checkOutput("divIgnored.done", 64'(donePulses), 64'd0);
      checkOutput("divIgnored.dataOut", bus.dataOut, held);
`endif

      // Asynchronous reset in the middle of a run discards the work in progress
      applyStimulus(DIVU, 32'hFFFFFFFF, 32'd3);
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("midReset.dataOut", bus.dataOut, 64'd0);
      checkOutput("midReset.busy", 64'(bus.busy), 64'd0);
      checkOutput("midReset.done", 64'(bus.done), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      busySeen = 0;
      donePulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.busy) busySeen++;
         if (bus.done) donePulses++;
      end
      checkOutput("midReset.staleBusy", 64'(busySeen), 64'd0);
      checkOutput("midReset.staleDone", 64'(donePulses), 64'd0);
      runOp("afterReset9div3", DIVU, 32'd9, 32'd3, 64'h00000000_00000003);

      for (int i = 0; i < 30; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic [5:0]  sig;
         int          pick;
         a    = $urandom;
         pick = $urandom_range(0, 7);
         if (pick == 0)      b = 32'd0;
         else if (pick < 4)  b = 32'($urandom_range(1, 255));
         else                b = $urandom;
         if (pick == 7) a = 32'h80000000;
         sig = DIVU;
`ifdef DIVIDER_SIGNED_EN
         if ($urandom_range(0, 1) == 1) sig = DIV;
`endif
         runOp($sformatf("rand%0d", i), sig, a, b, refModel(sig, a, b));
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand width (and 2*WIDTH as the result width).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 The module SHALL have port dataA, input, WIDTH bits: dividend.
REQ-005 The module SHALL have port dataB, input, WIDTH bits: divisor.
REQ-006 The module SHALL have port Signal, input, 6 bits: ALU function code (DIVU = 6'b011011, DIV = 6'b011010, OUT = 6'b111111).
REQ-007 The module SHALL have port dataOut, output, 2*WIDTH bits: {remainder, quotient}, registered.
REQ-008 The module SHALL have port busy, output, 1 bit: high while iterating.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse when dataOut is updated.

Function
REQ-010 The block SHALL use FSM states IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, Signal==DIVU SHALL capture dataA/dataB into internal registers, clear the 6-bit iteration counter, clear the partial remainder, and enter RUN.
REQ-012 RUN SHALL perform one restoring shift-subtract step per cycle, MSB of dividend first, for exactly WIDTH cycles.
- Step: rem = {rem, dividend MSB}.
- If rem >= divisor: rem -= divisor and quotient bit = 1; else quotient bit = 0.
REQ-013 On the WIDTH-th RUN cycle, the FSM SHALL load dataOut = {rem, quot}, pulse done for one cycle, and enter DONE.
- Latency: start sampled at edge N gives done high after edge N+WIDTH (33 edges for WIDTH=32).
REQ-014 busy SHALL be 1 exactly while in RUN.
REQ-015 Signal values SHALL be ignored while in RUN, including a new DIVU or DIV; dataA/dataB changes during RUN SHALL have no effect.
REQ-016 In DONE, Signal==OUT SHALL return the FSM to IDLE.
REQ-017 dataOut SHALL hold its value until the next completion or reset.
REQ-018 A divisor of 0 SHALL take the same WIDTH-cycle latency and yield quotient all-ones and remainder = dividend, with no error flag.
REQ-019 Any other Signal code SHALL leave the state unchanged.

Reset
REQ-020 reset=0 SHALL asynchronously force IDLE, dataOut=0, busy=0, done=0, counter=0 and all operand registers to 0, including mid-RUN; the aborted result SHALL be discarded.
REQ-021 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-022 With DIVIDER_SIGNED_EN defined, Signal==DIV SHALL start a signed two's-complement division.
- Operands are converted to magnitudes; the same unsigned core runs.
- Quotient sign = signA ^ signB; remainder sign = signA.
- Latency is unchanged.
- Most-negative / -1 yields quotient 0x80000000, remainder 0.
- Divide-by-zero follows REQ-018 on the magnitudes, then sign correction.
REQ-023 Without DIVIDER_SIGNED_EN, DIV SHALL be treated as an unrecognised code (REQ-019), and no sign logic SHALL be synthesised.

Structure
REQ-024 Package divider_pkg SHALL hold the Signal code constants (DIVU, DIV, OUT) and the FSM state typedef.
REQ-025 The single combinational restoring step SHALL be a sub-module div_step (inputs: rem, next bit, divisor; outputs: new rem, quotient bit), instantiated once in divider.

Verification
REQ-026 Unsigned basic: DIVU with dataA=100, dataB=7 -> done after 32 RUN cycles, dataOut = 64'h00000002_0000000E.
REQ-027 Divide by zero: DIVU with dataA=32'h12345678, dataB=0 -> dataOut = 64'h12345678_FFFFFFFF.
REQ-028 Reset mid-operation: start DIVU 0xFFFFFFFF/3, assert reset at RUN cycle 10 -> dataOut=0, busy=0 immediately; a following DIVU 9/3 -> 64'h00000000_00000003.
REQ-029 Ignored start: a second DIVU 50/5 issued during RUN of DIVU 81/9 -> only one done pulse, dataOut = 64'h00000000_00000009.
REQ-030 Signed (DIVIDER_SIGNED_EN): DIV with dataA=-7 (0xFFFFFFF9), dataB=2 -> dataOut = 64'hFFFFFFFF_FFFFFFFD; without the macro, the same stimulus -> no busy, no done, dataOut unchanged.
REQ-031 Back-to-back: DIVU 20/6 in DONE without OUT -> new run starts, dataOut = 64'h00000002_00000003.
